// File: rtl/clk_reset_seq_pkg.sv
// Shared types and elaboration helpers for the clocked reset/start sequencer.
// Group offsets follow the packed node order RESET,START,STEP,CAPTURE,PASSTHRU from bit 0.
package clk_reset_seq_pkg;

  typedef enum logic [2:0] {
    SYNC       = 3'd0,
    HOLD       = 3'd1,
    WAIT_CAP   = 3'd2,
    WAIT_START = 3'd3,
    RUN        = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(max3(a, b, c) + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  function automatic int start_off(input int resets);
    return resets;
  endfunction

  function automatic int step_off(input int resets, input int starts);
    return resets + starts;
  endfunction

  function automatic int cap_off(input int resets, input int starts, input int steps);
    return resets + starts + steps;
  endfunction

  function automatic int pass_off(input int resets, input int starts, input int steps,
                                  input int captures);
    return resets + starts + steps + captures;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the clock.
// rst_next_o is the value the output stage loads at the coming edge.
module rst_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_sync_o,
  output logic rst_next_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_o = sync_q;
  assign rst_next_o = meta_q;

endmodule

// File: rtl/clk_reset_seq.sv
// Clocked reset/start sequencer driving the RESET|START|STEP|CAPTURE|PASSTHRU node vector.
// Optional feature: define CLK_RESET_SEQ_STEP_EN for on-demand single-cycle STEP pulses.
module clk_reset_seq
  import clk_reset_seq_pkg::*;
#(
  parameter int RESETS         = 1,
  parameter int STARTS         = 0,
  parameter int STEPS          = 0,
  parameter int CAPTURES       = 0,
  parameter int PASSTHRUS      = 0,
  parameter int RESET_CYCLES   = 10,
  parameter int CAPTURE_CYCLES = 10,
  parameter int START_CYCLES   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
`ifdef CLK_RESET_SEQ_STEP_EN
  input  logic step_req,
  output logic step_ack,
`endif
  output logic [RESETS+STARTS+STEPS+CAPTURES+PASSTHRUS-1:0] reset_n,
  output logic done
);

  localparam int N  = RESETS + STARTS + STEPS + CAPTURES + PASSTHRUS;
  localparam int CW = cnt_width(RESET_CYCLES, CAPTURE_CYCLES, START_CYCLES);
  localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] CC_LAST = CW'(CAPTURE_CYCLES - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(START_CYCLES - 1);
  localparam bit HAS_CAP   = (CAPTURES > 0);
  localparam bit HAS_START = ((STARTS + STEPS) > 0);
  localparam bit HAS_LATER = ((STARTS + STEPS + CAPTURES) > 0);

  logic          rst_sync;
  logic          rst_next;
  logic          hold_ok;
  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          reset_up_q, reset_up_d;
  logic          cap_up_q,   cap_up_d;
  logic          start_up_q, start_up_d;
  logic          pass_up_q,  pass_up_d;
  logic          done_q,     done_d;

  rst_sync_2ff u_rst_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .rst_sync_o (rst_sync),
    .rst_next_o (rst_next)
  );

  // hold has no effect until the synchronizer has fully released
  assign hold_ok = hold && !rst_sync;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reset_up_d = reset_up_q;
    cap_up_d   = cap_up_q;
    start_up_d = start_up_q;
    pass_up_d  = pass_up_q;
    if (hold_ok && (state_q != SYNC)) begin
      state_d    = HOLD;
      cnt_d      = '0;
      reset_up_d = 1'b0;
      cap_up_d   = 1'b0;
      start_up_d = 1'b0;
    end else begin
      case (state_q)
        // leave SYNC on the same edge the second synchronizer stage releases
        SYNC: begin
          if (!rst_next) begin
            state_d   = HOLD;
            cnt_d     = '0;
            pass_up_d = 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == RC_LAST) begin
            cnt_d      = '0;
            reset_up_d = 1'b1;
            state_d    = HAS_LATER ? WAIT_CAP : RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_CAP: begin
          if (cnt_q == CC_LAST) begin
            cnt_d = '0;
            if (HAS_CAP) begin
              cap_up_d = 1'b1;
              state_d  = HAS_START ? WAIT_START : RUN;
            end else begin
              start_up_d = 1'b1;
              state_d    = RUN;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_START: begin
          if (cnt_q == SC_LAST) begin
            cnt_d      = '0;
            start_up_d = 1'b1;
            state_d    = RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = SYNC;
          cnt_d   = '0;
        end
      endcase
    end
    done_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      cnt_q      <= '0;
      reset_up_q <= 1'b0;
      cap_up_q   <= 1'b0;
      start_up_q <= 1'b0;
      pass_up_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reset_up_q <= reset_up_d;
      cap_up_q   <= cap_up_d;
      start_up_q <= start_up_d;
      pass_up_q  <= pass_up_d;
      done_q     <= done_d;
    end
  end

  assign done = done_q;

`ifdef CLK_RESET_SEQ_STEP_EN
  logic step_pulse_q, step_pulse_d;

  // a pulse in flight blocks the next request, so a held request pulses every other cycle
  always_comb begin
    step_pulse_d = (state_q == RUN) && !hold_ok && step_req && !step_pulse_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pulse_q <= 1'b0;
    end else begin
      step_pulse_q <= step_pulse_d;
    end
  end

  assign step_ack = step_pulse_q;
`endif

  for (genvar g = 0; g < RESETS; g++) begin : g_rst
    assign reset_n[g] = reset_up_q;
  end

  for (genvar g = 0; g < STARTS; g++) begin : g_start
    assign reset_n[start_off(RESETS) + g] = start_up_q;
  end

  for (genvar g = 0; g < STEPS; g++) begin : g_step
`ifdef CLK_RESET_SEQ_STEP_EN
    assign reset_n[step_off(RESETS, STARTS) + g] = step_pulse_q;
`else
    assign reset_n[step_off(RESETS, STARTS) + g] = start_up_q;
`endif
  end

  for (genvar g = 0; g < CAPTURES; g++) begin : g_cap
    assign reset_n[cap_off(RESETS, STARTS, STEPS) + g] = cap_up_q;
  end

  for (genvar g = 0; g < PASSTHRUS; g++) begin : g_pass
    assign reset_n[pass_off(RESETS, STARTS, STEPS, CAPTURES) + g] = pass_up_q;
  end

  a_param_range: assert property (@(posedge clk)
    (RESET_CYCLES >= 1) && (CAPTURE_CYCLES >= 1) && (START_CYCLES >= 1) && (N >= 1));

  a_groups_monotonic: assert property (@(posedge clk) disable iff (rst)
    ($fell(reset_up_q) || $fell(cap_up_q) || $fell(start_up_q)) |-> $past(hold_ok));

  a_passthru_sticky: assert property (@(posedge clk) disable iff (rst)
    !$fell(pass_up_q));

endmodule
